instr_encoder: RTL and testbench

//  Inverse of the core's immediate decoder: packs opcode/register/funct fields plus a 32-bit signed

---
 rtl/rv32_isa_pkg.sv | 34 +++
 rtl/imm_pack_enc.sv | 57 +++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_isa_pkg.sv
// RV32I encoding constants shared by the encode and decode sides.
package rv32_isa_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6,
    FMT_RSVD  = 3'd7
  } fmt_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when imm is representable as a signed value of the given bit width.
  function automatic logic fits_simm(logic [31:0] imm, int unsigned bits);
    logic [31:0] t;
    t = $signed(imm) >>> (bits - 1);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_pack_enc.sv
// Combinational RV32I field packer. Range checking is built in when IMM_RANGE_CHECK_EN is defined.
module imm_pack_enc
  import rv32_isa_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] packed_word;
  logic        range_bad;

  always_comb begin
    packed_word = NOP_INSTR;
    unique case (fmt)
      FMT_R:     packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:     packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:     packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:     packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:     packed_word = {imm[31:12], rd, opcode};
      FMT_J:     packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_SHIFT: packed_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_RSVD:  packed_word = NOP_INSTR;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    unique case (fmt)
      FMT_R:     range_bad = 1'b0;
      FMT_I:     range_bad = !fits_simm(imm, 12);
      FMT_S:     range_bad = !fits_simm(imm, 12);
      FMT_B:     range_bad = !fits_simm(imm, 13) || imm[0];
      FMT_U:     range_bad = (imm[11:0] != 12'd0);
      FMT_J:     range_bad = !fits_simm(imm, 21) || imm[0];
      FMT_SHIFT: range_bad = (imm[31:5] != 27'd0);
      FMT_RSVD:  range_bad = 1'b1;
    endcase
  end
`else
  assign range_bad = (fmt == FMT_RSVD);
`endif

  assign err   = range_bad;
  assign instr = range_bad ? NOP_INSTR : packed_word;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder with a registered 2-entry output buffer and accept/error counters.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import rv32_isa_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0] enc_instr;
  logic        enc_err;

  imm_pack_enc #(
    .NOP_INSTR(NOP_INSTR)
  ) u_pack (
    .fmt   (fmt_e'(in_fmt)),
    .opcode(in_opcode),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .funct3(in_funct3),
    .funct7(in_funct7),
    .imm   (in_imm),
    .instr (enc_instr),
    .err   (enc_err)
  );

  logic [1:0]       occ_q, occ_d;
  logic [31:0]      head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic             head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic             push, pop;

  assign in_ready  = rst_n && (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d        = occ_q;
    head_instr_d = head_instr_q;
    head_err_d   = head_err_q;
    tail_instr_d = tail_instr_q;
    tail_err_d   = tail_err_q;
    unique case (occ_q)
      2'd0: begin
        if (push) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
          occ_d        = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
        end else if (push) begin
          tail_instr_d = enc_instr;
          tail_err_d   = enc_err;
          occ_d        = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      2'd2: begin
        // Full: in_ready is low, so only a pop can happen here.
        if (pop) begin
          head_instr_d = tail_instr_q;
          head_err_d   = tail_err_q;
          occ_d        = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      enc_cnt_d = enc_cnt_q + 1'b1;
      if (enc_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q        <= 2'd0;
      head_instr_q <= 32'd0;
      head_err_q   <= 1'b0;
      tail_instr_q <= 32'd0;
      tail_err_q   <= 1'b0;
      enc_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      occ_q        <= occ_d;
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
      tail_instr_q <= tail_instr_d;
      tail_err_q   <= tail_err_d;
      enc_cnt_q    <= enc_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_instr = head_instr_q;
  assign out_err   = head_err_q;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder; expectations follow IMM_RANGE_CHECK_EN when defined.
module tb_instr_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  instr_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fmt   (in_fmt),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_err  (out_err),
    .enc_count(enc_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_fmt    = v.fmt;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t a0, a1, a2;
    logic [15:0] exp_errs;

    // fmt, op, rd, rs1, rs2, f3, f7, imm, expected instr, expected err
    vecs[0]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vecs[1]  = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0000_0463, 1'b0};
    vecs[2]  = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
    vecs[3]  = '{3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0};
    vecs[4]  = '{3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'hDEAD_BEEF,
                 32'h4020_81B3, 1'b0};
    vecs[5]  = '{3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE51_2E23, 1'b0};
    vecs[6]  = '{3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[7]  = '{3'd6, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd3, 32'h0031_1093, 1'b0};
    vecs[8]  = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0};
    vecs[9]  = '{3'd5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
    vecs[10] = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vecs[11] = '{3'd7, 7'b0110011, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h0000_0001, NOP, 1'b1};
    vecs[12] = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
                 CHK ? NOP : 32'h8000_0093, CHK};
    vecs[13] = '{3'd6, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd32,
                 CHK ? NOP : 32'h0001_1093, CHK};
    vecs[14] = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
                 CHK ? NOP : 32'h0000_0163, CHK};
    vecs[15] = '{3'd4, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001,
                 CHK ? NOP : 32'h0000_1037, CHK};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(vecs[0]);
    rst_n = 1'b0;
    tick();
    chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_err", {31'd0, out_err}, 32'd0);
    chk("reset_enc_count", {16'd0, enc_count}, 32'd0);
    chk("reset_err_count", {16'd0, err_count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    exp_errs = 16'd0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (vecs[i].exp_err) exp_errs++;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_enc_count", i), {16'd0, enc_count}, i + 1);
      chk($sformatf("vec%0d_err_count", i), {16'd0, err_count}, {16'd0, exp_errs});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: two accepted, third held, then three words on consecutive cycles.
    do_reset();
    #1;
    a0 = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0};
    a1 = '{3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0};
    a2 = '{3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0};
    drive(a0);
    in_valid = 1'b1;
    tick();
    drive(a1);
    tick();
    drive(a2);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_held_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_held_enc_count", {16'd0, enc_count}, 32'd2);
    chk("bp_head_stable", out_instr, a0.exp_instr);
    out_ready = 1'b1;
    tick();
    chk("bp_word1", out_instr, a1.exp_instr);
    chk("bp_after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_word2", out_instr, a2.exp_instr);
    chk("bp_word2_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_enc_count", {16'd0, enc_count}, 32'd3);
    tick();
    out_ready = 1'b0;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Mid-operation reset with two entries buffered.
    drive(a0);
    in_valid = 1'b1;
    tick();
    drive(a1);
    tick();
    in_valid = 1'b0;
    chk("rst_pre_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_low_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rst_stays_empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
